kmap_sweep_ctrl: RTL
====================

Name: kmap_sweep_ctrl

Overview:
- Sequencer that exhaustively drives a combinational K-map function unit and captures its full truth table.
- On a start pulse it steps the select inputs through every minterm index, with a programmable settle delay before each sample.
- It builds the minterm vector, counts the ones, and compares the result against an expected mask.
- It sits beside a 3-input kmap instance and is used for self-check and characterisation of the hand-minimised function.

Parameters:
- N_VARS, 3, number of function inputs; the minterm vector width is 2**N_VARS.
- SETTLE_CYCLES, 1, idle cycles after driving a new index and before sampling f_in; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; honoured only in IDLE.
- expected  input  2**N_VARS  golden minterm mask; latched in the cycle start is accepted.
- abc_out  output  N_VARS  drives the function inputs; MSB = a, LSB = c.
- f_in  input  1  function output returned from the kmap unit.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse when the sweep completes.
- match  output  1  minterms == latched expected; valid from done onward.
- minterms  output  2**N_VARS  bit i = f sampled at abc_out == i.
- ones_cnt  output  N_VARS+1  popcount of minterms.

Behaviour:
- Reset (synchronous): state = IDLE; all outputs 0; internal index, settle counter, shadow vector and shadow count are 0.
- A reset during a sweep aborts it. IDLE is entered the next cycle, no done is issued, and all results are cleared to 0.
- The FSM has four states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - abc_out = 0 and busy = 0.
  - On start = 1: latch expected, idx = 0, shadow vector = 0, shadow count = 0, settle counter = SETTLE_CYCLES.
  - Then go to SETTLE, or directly to SAMPLE if SETTLE_CYCLES == 0.
- SETTLE:
  - abc_out = idx.
  - The counter decrements each cycle. The FSM stays for exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE:
  - abc_out = idx. Update shadow[idx] <= f_in and shadow count += f_in.
  - If idx == 2**N_VARS-1, go to DONE.
  - Otherwise idx += 1, reload the settle counter, and go to SETTLE (or stay in SAMPLE for the next idx when SETTLE_CYCLES == 0).
- DONE:
  - done = 1 for exactly one cycle.
  - minterms, ones_cnt and match are registered from the shadow values in this same cycle. They are visible with done and held until the next DONE or reset.
  - abc_out returns to 0, then the FSM returns to IDLE.
- Outputs keep the previous sweep's values throughout a new sweep.
- start is ignored while busy, including in the DONE cycle. A new sweep needs start high in an IDLE cycle.
- Latency: start sampled in cycle 0 gives done in cycle 2**N_VARS*(SETTLE_CYCLES+1)+1.
  - Defaults: cycle 17.
  - SETTLE_CYCLES = 0: cycle 9.
- idx is an N_VARS-bit register and never wraps; the terminal index is detected explicitly.
- ones_cnt is wide enough for the all-ones case (8 → 4'b1000).
- The expected input is don't-care outside the start acceptance cycle.

Optional Feature:
- Macro: KMAP_SWEEP_ERRLOG_EN.
- When defined, three extra outputs are added:
  - err_cnt (N_VARS+1): number of indices where f_in != expected[idx], accumulated at each SAMPLE.
  - first_err_idx (N_VARS): lowest mismatching index.
  - err_valid (1): at least one mismatch.
- All three are registered in DONE alongside match, held until the next DONE, and reset to 0.
- Invariant: err_valid == !match.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst for 2 cycles → busy=0, done=0, abc_out=0, minterms=8'h00, ones_cnt=0, match=0.
- Golden sweep: connect the kmap F=A(B'+C)+A'BC'+B'C, expected=8'hB6, defaults, start in cycle 0.
  - abc_out steps 0..7, each held 2 cycles.
  - done in cycle 17, minterms=8'hB6, ones_cnt=5, match=1.
- Mismatch: same sweep with expected=8'hB7 → match=0.
  - With KMAP_SWEEP_ERRLOG_EN: err_cnt=1, first_err_idx=0, err_valid=1.
- Start while busy: pulse start again in cycles 5 and 17 (DONE) → exactly one done, in cycle 17, and busy=0 in cycle 18.
- Reset mid-sweep: rst in cycle 6 → busy=0 and all results 0 from cycle 7, with no done. A new start then completes with minterms=8'hB6.
- Zero settle: SETTLE_CYCLES=0, f_in tied 1, expected=8'hFF → done in cycle 9, minterms=8'hFF, ones_cnt=8, match=1.

Source files
------------

// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl
// Sweeps the select inputs of a combinational K-map unit through every
// minterm index. It waits a programmable settle time before each sample,
// then captures the truth table, counts its ones and compares the result
// against a golden mask.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   start     request a sweep (honoured only in IDLE)
//   expected  golden minterm mask, latched when start is accepted
//   abc_out   function select inputs (MSB = a, LSB = c)
//   f_in      function output returned from the K-map unit
//   busy      high from the cycle after start is accepted through DONE
//   done      one-cycle completion pulse
//   match     minterms == latched expected
//   minterms  captured truth table, bit i = f at abc_out == i
//   ones_cnt  popcount of minterms
//
// Optional build macro KMAP_SWEEP_ERRLOG_EN adds three outputs:
//   err_cnt        number of indices where f_in != expected[idx]
//   first_err_idx  lowest mismatching index
//   err_valid      at least one mismatch
//
// state  | meaning
// IDLE   | waiting for start; abc_out = 0
// SETTLE | index driven, waiting SETTLE_CYCLES before sampling
// SAMPLE | capture f_in for the current index
// DONE   | results visible, done pulse
module kmap_sweep_ctrl #(
    parameter int N_VARS        = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2**N_VARS-1:0]   expected,
    output logic [N_VARS-1:0]      abc_out,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic                   match,
    output logic [2**N_VARS-1:0]   minterms,
    output logic [N_VARS:0]        ones_cnt
`ifdef KMAP_SWEEP_ERRLOG_EN
    ,
    output logic [N_VARS:0]        err_cnt,
    output logic [N_VARS-1:0]      first_err_idx,
    output logic                   err_valid
`endif
);

    localparam int W = 2**N_VARS;
    localparam logic [N_VARS-1:0] IDX_LAST    = N_VARS'(W - 1);
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q;
    logic [N_VARS-1:0] idx_q;
    logic [3:0]        settle_cnt_q;
    logic [W-1:0]      exp_q;
    logic [W-1:0]      shadow_q;
    logic [N_VARS:0]   shadow_cnt_q;
    logic [W-1:0]      shadow_nxt;
    logic [N_VARS:0]   shadow_cnt_nxt;

    // Next shadow values include the current sample so the final SAMPLE
    // can publish complete results for the DONE cycle.
    always_comb begin
        shadow_nxt        = shadow_q;
        shadow_nxt[idx_q] = f_in;
        shadow_cnt_nxt    = shadow_cnt_q + {{N_VARS{1'b0}}, f_in};
    end

`ifdef KMAP_SWEEP_ERRLOG_EN
    logic [N_VARS:0]   err_cnt_q;
    logic [N_VARS-1:0] first_err_q;
    logic              err_seen_q;
    logic              mis;
    logic [N_VARS:0]   err_cnt_nxt;
    logic [N_VARS-1:0] first_err_nxt;
    logic              err_seen_nxt;

    // Indices are visited in ascending order, so the first mismatch seen
    // is the lowest one.
    always_comb begin
        mis           = f_in ^ exp_q[idx_q];
        err_cnt_nxt   = err_cnt_q + {{N_VARS{1'b0}}, mis};
        first_err_nxt = (mis && !err_seen_q) ? idx_q : first_err_q;
        err_seen_nxt  = err_seen_q | mis;
    end
`endif

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign abc_out = (state_q == S_SETTLE || state_q == S_SAMPLE) ? idx_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            exp_q        <= '0;
            shadow_q     <= '0;
            shadow_cnt_q <= '0;
            minterms     <= '0;
            ones_cnt     <= '0;
            match        <= 1'b0;
`ifdef KMAP_SWEEP_ERRLOG_EN
            err_cnt_q     <= '0;
            first_err_q   <= '0;
            err_seen_q    <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            err_valid     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        exp_q        <= expected;
                        idx_q        <= '0;
                        shadow_q     <= '0;
                        shadow_cnt_q <= '0;
                        settle_cnt_q <= SETTLE_LOAD;
`ifdef KMAP_SWEEP_ERRLOG_EN
                        err_cnt_q    <= '0;
                        first_err_q  <= '0;
                        err_seen_q   <= 1'b0;
`endif
                        state_q <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    settle_cnt_q <= settle_cnt_q - 4'd1;
                    if (settle_cnt_q == 4'd1) begin
                        state_q <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    shadow_q     <= shadow_nxt;
                    shadow_cnt_q <= shadow_cnt_nxt;
`ifdef KMAP_SWEEP_ERRLOG_EN
                    err_cnt_q    <= err_cnt_nxt;
                    first_err_q  <= first_err_nxt;
                    err_seen_q   <= err_seen_nxt;
`endif
                    if (idx_q == IDX_LAST) begin
                        minterms <= shadow_nxt;
                        ones_cnt <= shadow_cnt_nxt;
                        match    <= (shadow_nxt == exp_q);
`ifdef KMAP_SWEEP_ERRLOG_EN
                        err_cnt       <= err_cnt_nxt;
                        first_err_idx <= first_err_nxt;
                        err_valid     <= err_seen_nxt;
`endif
                        state_q <= S_DONE;
                    end else begin
                        idx_q        <= idx_q + N_VARS'(1);
                        settle_cnt_q <= SETTLE_LOAD;
                        state_q <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
